// File: rtl/store_narrow.sv
// store_narrow: store-path narrowing unit. Takes a register value with a
// byte/halfword/word size and byte address, and issues a word-aligned memory
// write with lane-replicated data and byte enables over a valid/ack handshake.
// Ports: clk, rst_n (async, active-low); req_valid/req_ready, req_addr,
// req_data, req_size (00 B, 01 H, 10 W, 11 reserved), req_unsigned;
// mem_we, mem_addr, mem_wdata, mem_be, mem_ack; done, err_align,
// err_timeout, err_range (one-cycle pulses).
// Optional: define STORE_RANGE_CHECK_EN to flag narrowing that loses
// information; otherwise err_range is tied low.
module store_narrow #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        done,
    output logic        err_align,
    output logic        err_timeout,
    output logic        err_range
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          done_q, done_d;
    logic          err_align_q, err_align_d;
    logic          err_timeout_q, err_timeout_d;

    logic          aligned;
    logic [31:0]   lane_data;
    logic [3:0]    lane_be;
    logic          accept_ok;

    // Alignment and little-endian lane placement of the incoming request.
    always_comb begin
        aligned   = 1'b0;
        lane_data = req_data;
        lane_be   = 4'b1111;
        unique case (req_size)
            2'b00: begin
                aligned   = 1'b1;
                lane_data = {4{req_data[7:0]}};
                lane_be   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                aligned   = ~req_addr[0];
                lane_data = {2{req_data[15:0]}};
                lane_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                aligned = (req_addr[1:0] == 2'b00);
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

    assign accept_ok = (state_q == IDLE) && req_valid && aligned;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        done_d        = 1'b0;
        err_align_d   = 1'b0;
        err_timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (aligned) begin
                        state_d     = WRITE;
                        cnt_d       = '0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = lane_data;
                        mem_be_d    = lane_be;
                    end else begin
                        err_align_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // Ack takes priority over an expiring timeout on the same edge.
                if (mem_ack) begin
                    state_d  = IDLE;
                    mem_we_d = 1'b0;
                    done_d   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    mem_we_d      = 1'b0;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            done_q        <= 1'b0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            done_q        <= done_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign done        = done_q;
    assign err_align   = err_align_q;
    assign err_timeout = err_timeout_q;

`ifdef STORE_RANGE_CHECK_EN
    logic range_bad;
    logic rng_q, rng_d;
    logic err_range_q, err_range_d;

    // Bits dropped by narrowing must all equal the sign bit (signed)
    // or be zero (unsigned).
    always_comb begin
        range_bad = 1'b0;
        unique case (req_size)
            2'b00: range_bad = req_unsigned ? (req_data[31:8] != 24'd0)
                             : (req_data[31:8] != {24{req_data[7]}});
            2'b01: range_bad = req_unsigned ? (req_data[31:16] != 16'd0)
                             : (req_data[31:16] != {16{req_data[15]}});
            default: range_bad = 1'b0;
        endcase
    end

    always_comb begin
        rng_d       = rng_q;
        err_range_d = 1'b0;
        if (accept_ok) begin
            rng_d = range_bad;
        end
        if ((state_q == WRITE) && mem_ack) begin
            err_range_d = rng_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rng_q       <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            rng_q       <= rng_d;
            err_range_q <= err_range_d;
        end
    end

    assign err_range = err_range_q;
`else
    logic unused_range_inputs;
    assign unused_range_inputs = req_unsigned ^ accept_ok;
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// tb_store_narrow: randomized scoreboard bench for store_narrow.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_store_narrow;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        err_align;
    logic        err_timeout;
    logic        err_range;

    store_narrow #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .done(done),
        .err_align(err_align), .err_timeout(err_timeout),
        .err_range(err_range)
    );

    always #5 clk = ~clk;

    // kind: 0 = done, 1 = err_align, 2 = err_timeout
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rng;
        int          cyc;
        int          we;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   we_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: what a store should do, from the size/address rules.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] s, input logic u);
        exp_t   e;
        int     off;
        longint sv;
        off     = int'(a % 4);
        sv      = longint'($signed(d));
        e.addr  = a - (a % 4);
        e.wdata = d;
        e.be    = 4'hF;
        e.rng   = 1'b0;
        e.cyc   = 0;
        e.we    = 0;
        case (s)
            2'd0: begin
                e.kind  = 0;
                e.wdata = (d & 32'hFF) * 32'h01010101;
                e.be    = 4'(1 << off);
                e.rng   = u ? (d > 32'd255) : (sv < -128 || sv > 127);
            end
            2'd1: begin
                e.kind  = (off % 2 == 0) ? 0 : 1;
                e.wdata = (d & 32'hFFFF) * 32'h00010001;
                e.be    = (off >= 2) ? 4'b1100 : 4'b0011;
                e.rng   = u ? (d > 32'd65535) : (sv < -32768 || sv > 32767);
            end
            2'd2: e.kind = (off == 0) ? 0 : 1;
            default: e.kind = 1;
        endcase
`ifndef STORE_RANGE_CHECK_EN
        e.rng = 1'b0;
`endif
        return e;
    endfunction

    // Called #1 after a rising edge with the DUT idle. ackd = WRITE cycle
    // (1-based) in which ack is raised; ackd > T means never.
    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic u, input int ackd);
        exp_t e;
        int   n;
        e = model(a, d, s, u);
        n = cyc + 1;
        if (e.kind == 1) begin
            e.cyc = n;
            e.we  = 0;
            e.rng = 1'b0;
        end else if (ackd <= T) begin
            e.cyc = n + ackd;
            e.we  = ackd;
        end else begin
            e.kind = 2;
            e.cyc  = n + T;
            e.we   = T;
            e.rng  = 1'b0;
        end
        sb.push_back(e);
        req_valid = 1'b1;
        req_addr = a;
        req_data = d;
        req_size = s;
        req_unsigned = u;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (e.kind != 1) begin
            for (int j = 1; j <= T; j++) begin
                mem_ack = (j == ackd);
                @(posedge clk); #1;
                if (j == ackd) break;
            end
            mem_ack = 1'b0;
        end
    endtask

    // Monitor: every response pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        int   np;
        if (!rst_n) begin
            we_cnt = 0;
        end else begin
            if (mem_we) we_cnt++;
            np = int'(done) + int'(err_align) + int'(err_timeout);
            if (np != 0) begin
                k = done ? 0 : (err_align ? 1 : 2);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)",
                             k, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("one_pulse", np, 1);
                    chk("kind", k, e.kind);
                    chk("latency_cycle", cyc, e.cyc);
                    chk("we_cycles", we_cnt, e.we);
                    chk("req_ready", req_ready, 1'b1);
                    chk("mem_we_low", mem_we, 1'b0);
                    chk("err_range", err_range, e.rng);
                    if (e.kind != 1) begin
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_wdata", mem_wdata, e.wdata);
                        chk("mem_be", mem_be, e.be);
                    end
                end
                we_cnt = 0;
            end else if (err_range) begin
                chk("stray_err_range", err_range, 1'b0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [1:0]  s;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_size = '0;
        req_unsigned = 1'b0;
        mem_ack = 1'b0;
        #12;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", mem_be, 4'h0);
        chk("rst_pulses", {done, err_align, err_timeout, err_range}, 4'h0);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(32'h1003, 32'h000000A5, 2'd0, 1'b0, 1);
        issue(32'h2002, 32'hFFFF8001, 2'd1, 1'b0, 1);
        issue(32'h2002, 32'hFFFF8001, 2'd1, 1'b1, 1);
        issue(32'h3001, 32'h12345678, 2'd1, 1'b0, 1);
        issue(32'h3002, 32'h12345678, 2'd2, 1'b0, 1);
        issue(32'h3000, 32'h12345678, 2'd3, 1'b0, 1);
        issue(32'h4000, 32'hCAFEF00D, 2'd2, 1'b0, T + 1);
        issue(32'h4000, 32'hCAFEF00D, 2'd2, 1'b0, T);

        // Reset while writing.
        req_valid = 1'b1;
        req_addr = 32'h5000;
        req_data = 32'h11223344;
        req_size = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("we_before_rst", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", mem_we, 1'b0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        chk("rst_mid_wdata", mem_wdata, 32'h0);
        chk("rst_mid_be", mem_be, 4'h0);
        chk("rst_mid_ready", req_ready, 1'b1);
        chk("rst_mid_pulses", {done, err_align, err_timeout, err_range}, 4'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h6004, 32'h89ABCDEF, 2'd2, 1'b0, 2);

        // Stray ack in idle, then a store that sees ack immediately.
        mem_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        issue(32'h7001, 32'h0000007F, 2'd0, 1'b0, 1);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: d = $urandom;
                1: d = {{24{1'($urandom_range(0, 1))}}, 8'($urandom)};
                default: d = {{16{1'($urandom_range(0, 1))}}, 16'($urandom)};
            endcase
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            issue(a, d, s, 1'($urandom_range(0, 1)), $urandom_range(1, T + 2));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
